gbdt_regfile_banked: RTL and testbench

Parametrised successor to the GBDT APB register file and RAM bank. It holds NUM_GROUPS×RAMS_PER_GROUP class RAMs, each built from SUB_BANKS sub-RAMs. The APB side loads and reads back tree data through a data-port register with optional address auto-increment. The GBDT core reads one class RAM per group per round. Shared buses use registered muxes instead of tri-states, and ownership passes between APB and core under `gbdt_busy`.

---
 rtl/gbdt_regfile_banked_pkg.sv | 32 +++
 rtl/gbdt_regfile_banked_if.sv | 16 +
 rtl/gbdt_regfile_banked_ram_class.sv | 62 ++++++
 rtl/gbdt_regfile_banked.sv | 186 ++++++++++++++++++
 tb/tb_gbdt_regfile_banked.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gbdt_regfile_banked_pkg.sv
// Register map, STATUS bits, APB FSM encoding and width helpers for gbdt_regfile_banked.
package gbdt_regfile_pkg;
  localparam logic [7:0] REG_RAM_ADDR  = 8'h00;
  localparam logic [7:0] REG_RAM_DATA  = 8'h04;
  localparam logic [7:0] REG_SEL       = 8'h08;
  localparam logic [7:0] REG_START     = 8'h0C;
  localparam logic [7:0] REG_USEDCLASS = 8'h10;
  localparam logic [7:0] REG_MAX_CLASS = 8'h14;
  localparam logic [7:0] REG_MAX_SCORE = 8'h18;
  localparam logic [7:0] REG_STATUS    = 8'h1C;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

  typedef enum logic [1:0] {
    APB_IDLE    = 2'd0,
    APB_RD_WAIT = 2'd1,
    APB_RESP    = 2'd2
  } apb_state_t;

  function automatic int class_w(input int ng, input int rpg);
    return $clog2(ng * rpg);
  endfunction

  function automatic int round_w(input int rpg);
    return (rpg > 1) ? $clog2(rpg) : 1;
  endfunction

  function automatic int addr_w(input int sb, input int saw);
    return $clog2(sb) + saw;
  endfunction
endpackage

// File: rtl/gbdt_regfile_banked_if.sv
// APB-style register bus between a host master and the banked GBDT register file.
interface gbdt_regfile_banked_if;
  // Handshake: the master raises p_sel with p_write/p_addr/p_wdata for one cycle to request a
  // transfer; the slave completes it with p_ready high for exactly one cycle, and p_rdata and
  // p_slverr are valid only in that cycle.
  logic        p_sel;
  logic        p_write;
  logic [7:0]  p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        p_slverr;

  modport master (output p_sel, p_write, p_addr, p_wdata, input p_rdata, p_ready, p_slverr);
  modport slave  (input p_sel, p_write, p_addr, p_wdata, output p_rdata, p_ready, p_slverr);
endinterface

// File: rtl/gbdt_regfile_banked_ram_class.sv
// One class RAM built from SUB_BANKS single-port sub-RAMs, plus the sub-RAM macro model.
module spram32x4096_cb #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= d;
      else    q <= mem[addr];
    end
  end
endmodule

module gbdt_ram_class import gbdt_regfile_pkg::*; #(
  parameter  int SUB_BANKS      = 4,
  parameter  int SUB_ADDR_WIDTH = 12,
  parameter  int RAM_DATA_WIDTH = 32,
  localparam int BANK_W         = $clog2(SUB_BANKS),
  localparam int AW             = addr_w(SUB_BANKS, SUB_ADDR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      we,
  input  logic [AW-1:0]             addr,
  input  logic [RAM_DATA_WIDTH-1:0] wdata,
  output logic [RAM_DATA_WIDTH-1:0] rdata
);
  logic [BANK_W-1:0]         bank;
  logic [BANK_W-1:0]         bank_q;
  logic [RAM_DATA_WIDTH-1:0] sub_q [SUB_BANKS];

  assign bank = addr[AW-1 -: BANK_W];

  for (genvar b = 0; b < SUB_BANKS; b++) begin : g_sub
    spram32x4096_cb #(.AW(SUB_ADDR_WIDTH), .DW(RAM_DATA_WIDTH)) u_ram (
      .clk  (clk),
      .cs   (cs && (bank == BANK_W'(b))),
      .we   (we),
      .addr (addr[SUB_ADDR_WIDTH-1:0]),
      .d    (wdata),
      .q    (sub_q[b])
    );
  end

  // The sub-RAM output lags its address by a cycle, so steer the mux with the bank of that access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  bank_q <= '0;
    else if (cs) bank_q <= bank;
  end

  assign rdata = sub_q[bank_q];
endmodule

// File: rtl/gbdt_regfile_banked.sv
// Banked GBDT register file: APB load/readback of class RAMs, per-group core reads under gbdt_busy.
// Optional feature macro GBDT_ADDR_AUTOINC_EN: successful RAM_DATA accesses post-increment RAM_ADDR.
module gbdt_regfile_banked import gbdt_regfile_pkg::*; #(
  parameter  int NUM_GROUPS     = 8,
  parameter  int RAMS_PER_GROUP = 4,
  parameter  int SUB_BANKS      = 4,
  parameter  int SUB_ADDR_WIDTH = 12,
  parameter  int RAM_DATA_WIDTH = 32,
  localparam int NUM_CLASSES    = NUM_GROUPS * RAMS_PER_GROUP,
  localparam int CW             = class_w(NUM_GROUPS, RAMS_PER_GROUP),
  localparam int RW             = round_w(RAMS_PER_GROUP),
  localparam int AW             = addr_w(SUB_BANKS, SUB_ADDR_WIDTH)
) (
  input  logic                      gbdt_clk,
  input  logic                      gbdt_rst_n,
  gbdt_regfile_banked_if.slave      apb,
  input  logic                      gbdt_busy,
  input  logic                      core_cs,
  input  logic [RW-1:0]             core_round,
  input  logic [AW-1:0]             core_addr [NUM_GROUPS],
  output logic [RAM_DATA_WIDTH-1:0] core_data [NUM_GROUPS],
  output logic                      core_valid,
  input  logic                      new_max_valid,
  input  logic [31:0]               new_max_result,
  input  logic [CW-1:0]             new_max_class,
  output logic                      gbdt_start,
  output logic [31:0]               used_classes,
  output apb_state_t                fsm_state
);
  apb_state_t                state, state_n;
  logic [AW-1:0]             ram_addr;
  logic [31:0]               sel;
  logic                      err_sticky;
  logic [CW-1:0]             max_class;
  logic [31:0]               max_score;
  logic [31:0]               reg_rdata;
  logic                      apb_go, ram_hit, ram_err, ram_ok;
  logic                      core_go, core_pend;
  logic [RW-1:0]             pend_round, round_eff, round_q;
  logic [AW-1:0]             pend_addr [NUM_GROUPS];
  logic [AW-1:0]             addr_eff  [NUM_GROUPS];
  logic [RAM_DATA_WIDTH-1:0] class_rdata [NUM_CLASSES];

  // Gating with reset keeps an IDLE-state request from writing a RAM while reset is asserted.
  assign apb_go  = (state == APB_IDLE) && apb.p_sel && gbdt_rst_n;
  assign ram_hit = (apb.p_addr == REG_RAM_DATA);
  assign ram_err = gbdt_busy || (sel >= 32'(NUM_CLASSES));
  assign ram_ok  = apb_go && ram_hit && !ram_err;

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) state <= APB_IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      APB_IDLE:    if (apb_go) state_n = (ram_ok && !apb.p_write) ? APB_RD_WAIT : APB_RESP;
      APB_RD_WAIT: state_n = APB_RESP;
      APB_RESP:    state_n = APB_IDLE;
      default:     state_n = APB_IDLE;
    endcase
  end

  always_comb begin
    apb.p_ready = (state == APB_RESP);
    fsm_state   = state;
  end

  always_comb begin
    reg_rdata = '0;
    case (apb.p_addr)
      REG_RAM_ADDR:  reg_rdata = 32'(ram_addr);
      REG_SEL:       reg_rdata = sel;
      REG_USEDCLASS: reg_rdata = used_classes;
      REG_MAX_CLASS: reg_rdata = 32'(max_class);
      REG_MAX_SCORE: reg_rdata = max_score;
      REG_STATUS: begin
        reg_rdata[STATUS_BUSY_BIT] = gbdt_busy;
        reg_rdata[STATUS_ERR_BIT]  = err_sticky;
      end
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      apb.p_rdata  <= '0;
      apb.p_slverr <= 1'b0;
      gbdt_start   <= 1'b0;
      ram_addr     <= '0;
      sel          <= '0;
      used_classes <= '1;
      err_sticky   <= 1'b0;
    end else begin
      gbdt_start <= 1'b0;
      if (state == APB_RD_WAIT) apb.p_rdata <= class_rdata[sel[CW-1:0]];
      if (apb_go) begin
        apb.p_slverr <= ram_hit && ram_err;
        apb.p_rdata  <= '0;
        if (ram_hit && ram_err) err_sticky <= 1'b1;
        if (apb.p_write) begin
          case (apb.p_addr)
            REG_RAM_ADDR:  ram_addr     <= apb.p_wdata[AW-1:0];
            REG_SEL:       sel          <= apb.p_wdata;
            REG_START:     gbdt_start   <= apb.p_wdata[0];
            REG_USEDCLASS: used_classes <= apb.p_wdata;
            default: ;
          endcase
        end else begin
          apb.p_rdata <= reg_rdata;
          if (apb.p_addr == REG_STATUS) err_sticky <= 1'b0;
        end
`ifdef GBDT_ADDR_AUTOINC_EN
        if (ram_ok) ram_addr <= ram_addr + 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      max_class <= '0;
      max_score <= '0;
    end else if (new_max_valid) begin
      max_class <= new_max_class;
      max_score <= new_max_result;
    end
  end

  // A core request arriving while an APB RAM read is in flight is parked and replayed next cycle.
  assign core_go   = gbdt_busy && (state != APB_RD_WAIT) && (core_cs || core_pend);
  assign round_eff = core_pend ? pend_round : core_round;
  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) addr_eff[g] = core_pend ? pend_addr[g] : core_addr[g];
  end

  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      core_pend  <= 1'b0;
      pend_round <= '0;
      pend_addr  <= '{default: '0};
      core_valid <= 1'b0;
      round_q    <= '0;
    end else begin
      core_pend  <= gbdt_busy && core_cs && ((state == APB_RD_WAIT) || core_pend);
      core_valid <= core_go;
      if (core_cs) begin
        pend_round <= core_round;
        pend_addr  <= core_addr;
      end
      if (core_go) round_q <= round_eff;
    end
  end

  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++)
      core_data[g] = core_valid ? class_rdata[CW'(g + NUM_GROUPS * int'(round_q))] : '0;
  end

  for (genvar r = 0; r < RAMS_PER_GROUP; r++) begin : g_round
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
      localparam int C = g + NUM_GROUPS * r;
      logic          cls_cs;
      logic [AW-1:0] cls_addr;

      assign cls_cs   = gbdt_busy ? (core_go && (round_eff == RW'(r)))
                                  : (ram_ok && (sel[CW-1:0] == CW'(C)));
      assign cls_addr = gbdt_busy ? addr_eff[g] : ram_addr;

      gbdt_ram_class #(
        .SUB_BANKS      (SUB_BANKS),
        .SUB_ADDR_WIDTH (SUB_ADDR_WIDTH),
        .RAM_DATA_WIDTH (RAM_DATA_WIDTH)
      ) u_class (
        .clk   (gbdt_clk),
        .rst_n (gbdt_rst_n),
        .cs    (cls_cs),
        .we    (!gbdt_busy && apb.p_write),
        .addr  (cls_addr),
        .wdata (apb.p_wdata),
        .rdata (class_rdata[C])
      );
    end
  end
endmodule

// File: tb/tb_gbdt_regfile_banked.sv
// Directed self-checking bench for gbdt_regfile_banked with hand-computed expectations.
`timescale 1ns/1ps
module tb_gbdt_regfile_banked;
  import gbdt_regfile_pkg::*;

  localparam int NG = 8;
  localparam int RW = 2;
  localparam int CW = 5;
  localparam int AW = 14;
  localparam int DW = 32;
`ifdef GBDT_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          gbdt_busy, core_cs, core_valid, new_max_valid, gbdt_start;
  logic [RW-1:0] core_round;
  logic [AW-1:0] core_addr [NG];
  logic [DW-1:0] core_data [NG];
  logic [31:0]   new_max_result, used_classes;
  logic [CW-1:0] new_max_class;
  apb_state_t    fsm_state;

  gbdt_regfile_banked_if apb();

  gbdt_regfile_banked dut (
    .gbdt_clk       (clk),
    .gbdt_rst_n     (rst_n),
    .apb            (apb),
    .gbdt_busy      (gbdt_busy),
    .core_cs        (core_cs),
    .core_round     (core_round),
    .core_addr      (core_addr),
    .core_data      (core_data),
    .core_valid     (core_valid),
    .new_max_valid  (new_max_valid),
    .new_max_result (new_max_result),
    .new_max_class  (new_max_class),
    .gbdt_start     (gbdt_start),
    .used_classes   (used_classes),
    .fsm_state      (fsm_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  int          start_cnt = 0;
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) if (gbdt_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
    bit done;
    done = 1'b0;
    @(negedge clk);
    apb.p_sel = 1'b1; apb.p_write = wr; apb.p_addr = addr; apb.p_wdata = wdata;
    @(posedge clk);
    #1 apb.p_sel = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (apb.p_ready) begin
        done = 1'b1; rdata = apb.p_rdata; err = apb.p_slverr;
      end
    end
    if (!done) check("apb_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] r; logic e; int l;
    apb_xfer(1'b1, addr, data, r, e, l);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    logic e; int l;
    apb_xfer(1'b0, addr, 32'd0, data, e, l);
  endtask

  task automatic ram_write(input logic [31:0] cls, input logic [31:0] addr, input logic [31:0] data);
    wr(REG_SEL, cls); wr(REG_RAM_ADDR, addr); wr(REG_RAM_DATA, data);
  endtask

  task automatic ram_read(input logic [31:0] cls, input logic [31:0] addr, output logic [31:0] data);
    wr(REG_SEL, cls); wr(REG_RAM_ADDR, addr); rd(REG_RAM_DATA, data);
  endtask

  initial begin
    logic [31:0] d;
    logic e;
    int l, s0;

    apb.p_sel = 1'b0; apb.p_write = 1'b0; apb.p_addr = '0; apb.p_wdata = '0;
    gbdt_busy = 1'b0; core_cs = 1'b0; core_round = '0;
    new_max_valid = 1'b0; new_max_result = '0; new_max_class = '0;
    for (int g = 0; g < NG; g++) core_addr[g] = '0;
    repeat (3) @(negedge clk);

    check("rst_p_ready", 32'(apb.p_ready), 32'd0);
    check("rst_p_rdata", apb.p_rdata, 32'd0);
    check("rst_p_slverr", 32'(apb.p_slverr), 32'd0);
    check("rst_start", 32'(gbdt_start), 32'd0);
    check("rst_core_valid", 32'(core_valid), 32'd0);
    check("rst_core_data3", core_data[3], 32'd0);
    check("rst_used", used_classes, 32'hFFFF_FFFF);
    check("rst_fsm", 32'(fsm_state), 32'(APB_IDLE));
    rst_n = 1'b1;
    rd(REG_RAM_ADDR, d);  check("rst_ram_addr", d, 32'd0);
    rd(REG_SEL, d);       check("rst_sel", d, 32'd0);
    rd(REG_MAX_SCORE, d); check("rst_max_score", d, 32'd0);
    rd(REG_MAX_CLASS, d); check("rst_max_class", d, 32'd0);

    // basic write / readback with latency
    wr(REG_SEL, 32'd5);
    wr(REG_RAM_ADDR, 32'h1003);
    wr(REG_RAM_DATA, 32'hDEAD_BEEF);
    wr(REG_RAM_ADDR, 32'h1003);
    apb_xfer(1'b0, REG_RAM_DATA, 32'd0, d, e, l);
    check("rd_data", d, 32'hDEAD_BEEF);
    check("rd_lat", 32'(l), 32'd2);
    check("rd_err", 32'(e), 32'd0);
    rd(REG_RAM_ADDR, d);
    check("addr_after_rd", d, AUTOINC ? 32'h1004 : 32'h1003);
    apb_xfer(1'b0, REG_SEL, 32'd0, d, e, l);
    check("sel_rd", d, 32'd5);
    check("reg_lat", 32'(l), 32'd1);

    // other sub-bank, same physical address
    ram_write(32'd5, 32'h0003, 32'hA5A5_A5A5);
    ram_read(32'd5, 32'h1003, d); check("bank1_keep", d, 32'hDEAD_BEEF);
    ram_read(32'd5, 32'h0003, d); check("bank0_data", d, 32'hA5A5_A5A5);

    // RAM_ADDR behaviour across consecutive data writes
    wr(REG_RAM_ADDR, 32'h3FFF);
    wr(REG_RAM_DATA, 32'h11);
    wr(REG_RAM_DATA, 32'h22);
    rd(REG_RAM_ADDR, d);
`ifdef GBDT_ADDR_AUTOINC_EN
    check("autoinc_wrap", d, 32'h0001);
    wr(REG_RAM_ADDR, 32'h3FFF); rd(REG_RAM_DATA, d); check("autoinc_w0", d, 32'h11);
    wr(REG_RAM_ADDR, 32'h0000); rd(REG_RAM_DATA, d); check("autoinc_w1", d, 32'h22);
`else
    check("addr_static", d, 32'h3FFF);
    rd(REG_RAM_DATA, d); check("overwrite", d, 32'h22);
`endif

    // out-of-range class select
    wr(REG_RAM_ADDR, 32'h0200);
    wr(REG_SEL, 32'd32);
    apb_xfer(1'b1, REG_RAM_DATA, 32'h77, d, e, l);
    check("sel_err", 32'(e), 32'd1);
    rd(REG_STATUS, d); check("status_err", d, 32'h2);
    rd(REG_STATUS, d); check("status_clr", d, 32'h0);
    rd(REG_RAM_ADDR, d); check("err_no_inc", d, 32'h0200);

    // preload round 2 for core reads
    for (int g = 0; g < NG; g++) begin
      ram_write(32'(g + 16), 32'd7, 32'(g));
      ram_write(32'(g + 16), 32'd8, 32'(g + 100));
    end

    // core_cs ignored while the APB side owns the RAMs
    @(negedge clk);
    core_round = 2'd2; core_cs = 1'b1;
    for (int g = 0; g < NG; g++) core_addr[g] = 14'd7;
    @(negedge clk);
    core_cs = 1'b0;
    @(negedge clk);
    check("idle_core_valid", 32'(core_valid), 32'd0);

    // back-to-back core reads
    gbdt_busy = 1'b1; core_cs = 1'b1;
    for (int g = 0; g < NG; g++) exp_q.push_back(32'(g));
    for (int g = 0; g < NG; g++) exp_q.push_back(32'(g + 100));
    @(negedge clk);
    for (int g = 0; g < NG; g++) core_addr[g] = 14'd8;
    check("core_valid0", 32'(core_valid), 32'd1);
    for (int g = 0; g < NG; g++) check($sformatf("core_a7_g%0d", g), core_data[g], exp_q.pop_front());
    @(negedge clk);
    core_cs = 1'b0;
    check("core_valid1", 32'(core_valid), 32'd1);
    for (int g = 0; g < NG; g++) check($sformatf("core_a8_g%0d", g), core_data[g], exp_q.pop_front());
    @(negedge clk);
    check("core_valid_off", 32'(core_valid), 32'd0);

    // APB while the core owns the RAMs
    apb_xfer(1'b1, REG_RAM_DATA, 32'h55, d, e, l);
    check("busy_err", 32'(e), 32'd1);
    rd(REG_STATUS, d); check("status_busy", d, 32'h3);
    s0 = start_cnt;
    apb_xfer(1'b1, REG_START, 32'd1, d, e, l);
    @(negedge clk);
    check("start_pulse", 32'(start_cnt - s0), 32'd1);
    s0 = start_cnt;
    wr(REG_START, 32'd0);
    @(negedge clk);
    check("start_zero", 32'(start_cnt - s0), 32'd0);
    gbdt_busy = 1'b0;
    ram_read(32'd5, 32'h1003, d); check("busy_no_write", d, 32'hDEAD_BEEF);

    // gbdt_busy rises during RD_WAIT with a simultaneous core request
    wr(REG_SEL, 32'd5); wr(REG_RAM_ADDR, 32'h1003);
    for (int g = 0; g < NG; g++) core_addr[g] = 14'd7;
    @(negedge clk);
    apb.p_sel = 1'b1; apb.p_write = 1'b0; apb.p_addr = REG_RAM_DATA;
    @(posedge clk);
    #1 apb.p_sel = 1'b0; gbdt_busy = 1'b1; core_cs = 1'b1;
    @(posedge clk);
    #1 core_cs = 1'b0;
    @(negedge clk);
    check("race_ready", 32'(apb.p_ready), 32'd1);
    check("race_rdata", apb.p_rdata, 32'hDEAD_BEEF);
    check("race_err", 32'(apb.p_slverr), 32'd0);
    check("race_core_early", 32'(core_valid), 32'd0);
    @(negedge clk);
    check("race_core_valid", 32'(core_valid), 32'd1);
    for (int g = 0; g < NG; g++) check($sformatf("race_g%0d", g), core_data[g], 32'(g));
    gbdt_busy = 1'b0;

    // max capture only on strobe
    @(negedge clk);
    new_max_result = 32'hCAFE_F00D; new_max_class = 5'd13; new_max_valid = 1'b1;
    @(negedge clk);
    new_max_valid = 1'b0; new_max_result = 32'h1; new_max_class = 5'd2;
    rd(REG_MAX_SCORE, d); check("max_score", d, 32'hCAFE_F00D);
    rd(REG_MAX_CLASS, d); check("max_class", d, 32'd13);

    // undefined address and USEDCLASS
    apb_xfer(1'b0, 8'h20, 32'd0, d, e, l);
    check("undef_rd", d, 32'd0);
    check("undef_err", 32'(e), 32'd0);
    wr(REG_USEDCLASS, 32'h0000_00FF);
    check("used_port", used_classes, 32'h0000_00FF);

    // reset while in RD_WAIT
    @(negedge clk);
    apb.p_sel = 1'b1; apb.p_write = 1'b0; apb.p_addr = REG_RAM_DATA;
    @(posedge clk);
    #1 apb.p_sel = 1'b0;
    check("pre_rst_fsm", 32'(fsm_state), 32'(APB_RD_WAIT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(apb.p_ready), 32'd0);
    check("mid_rst_fsm", 32'(fsm_state), 32'(APB_IDLE));
    check("mid_rst_used", used_classes, 32'hFFFF_FFFF);
    @(negedge clk);
    check("mid_rst_ready2", 32'(apb.p_ready), 32'd0);
    rst_n = 1'b1;
    rd(REG_SEL, d); check("post_rst_sel", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
